// File: rtl/mux_n_1_scan_if.sv
// Bus bundle for mux_n_1_scan: channel data, select/scan controls and registered outputs.
// The Y_PAR signal exists only when MUX_PARITY_EN is defined.
interface mux_n_1_scan_if #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*W-1:0]     D;
    logic [SEL_W-1:0]   S;
    logic               MODE;
    logic               EN;
    logic [N-1:0]       MASK;
    logic [DWELL_W-1:0] DWELL;
    logic [W-1:0]       Y;
    logic [SEL_W-1:0]   CH;
    logic               Y_VALID;
    logic               WRAP;
`ifdef MUX_PARITY_EN
    logic               Y_PAR;
`endif

    modport master (
        output D, S, MODE, EN, MASK, DWELL,
        input  Y, CH, Y_VALID, WRAP
`ifdef MUX_PARITY_EN
        , input Y_PAR
`endif
    );

    modport slave (
        input  D, S, MODE, EN, MASK, DWELL,
        output Y, CH, Y_VALID, WRAP
`ifdef MUX_PARITY_EN
        , output Y_PAR
`endif
    );
endinterface

// File: rtl/mux_n_1_scan.sv
// N-channel registered mux with manual select and masked round-robin scan with dwell.
// Define MUX_PARITY_EN to add the registered even-parity output Y_PAR.
module mux_n_1_scan #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_n_1_scan_if.slave  bus
);
    localparam int SEL_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       y_q, y_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               y_valid_q, y_valid_d;
    logic               wrap_q, wrap_d;

    logic [SEL_W-1:0]   sel_idx, first_idx, next_idx;
    logic               sel_in_range;
    logic [W-1:0]       sel_data;
    int                 scan_idx;

    // Channel data mux plus the two scan-pointer searches.
    always_comb begin
        sel_idx      = (state_d == SCAN) ? ptr_q : bus.S;
        sel_in_range = 1'b0;
        sel_data     = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel_idx) == i) begin
                sel_in_range = 1'b1;
                sel_data     = bus.D[i*W +: W];
            end
        end
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.MASK[i]) first_idx = SEL_W'(i);
        end
        // Downward walk so the nearest set bit after ptr wins; k=N lands back on ptr.
        next_idx = ptr_q;
        scan_idx = 0;
        for (int k = N; k >= 1; k--) begin
            scan_idx = (int'(ptr_q) + k) % N;
            if (bus.MASK[scan_idx]) next_idx = SEL_W'(scan_idx);
        end
    end

    always_comb begin
        if (!bus.EN)       state_d = IDLE;
        else if (bus.MODE) state_d = SCAN;
        else               state_d = MANUAL;
    end

    always_comb begin
        y_d       = y_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        y_valid_d = 1'b0;
        wrap_d    = 1'b0;
        case (state_d)
            MANUAL: begin
                ch_d      = bus.S;
                y_d       = sel_in_range ? sel_data : '0;
                y_valid_d = sel_in_range;
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    if (|bus.MASK) ptr_d = first_idx;
                    cnt_d = '0;
                end else if (|bus.MASK) begin
                    y_d       = sel_data;
                    ch_d      = ptr_q;
                    y_valid_d = bus.MASK[ptr_q];
                    // >= so a DWELL lowered below the running count advances at once.
                    if (!bus.MASK[ptr_q] || cnt_q >= bus.DWELL) begin
                        ptr_d  = next_idx;
                        cnt_d  = '0;
                        wrap_d = (next_idx <= ptr_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef MUX_PARITY_EN
    logic y_par_q;
    assign bus.Y_PAR = y_par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            ch_q      <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef MUX_PARITY_EN
            y_par_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            y_valid_q <= y_valid_d;
            wrap_q    <= wrap_d;
`ifdef MUX_PARITY_EN
            y_par_q   <= ^y_d;
`endif
        end
    end

    assign bus.Y       = y_q;
    assign bus.CH      = ch_q;
    assign bus.Y_VALID = y_valid_q;
    assign bus.WRAP    = wrap_q;
endmodule
